// File: rtl/prbs31_checker_if.sv
// rtl/prbs31_checker_if.sv - serial pattern input bundle for the PRBS31 checker
interface prbs31_checker_if;
  logic rx_bit;
  logic rx_valid;

  modport master (output rx_bit, output rx_valid);
  modport slave  (input  rx_bit, input  rx_valid);
endinterface

// File: rtl/prbs31_checker.sv
// rtl/prbs31_checker.sv - self-synchronising PRBS31 (x^31 + x^28 + 1) receive checker
module prbs31_checker #(
  parameter int LOCK_CNT    = 64,
  parameter int WIN_LEN     = 64,
  parameter int LOSS_THRESH = 8,
  parameter int ERR_W       = 16,
  parameter int BIT_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  prbs31_checker_if.slave     rx,
  input  logic                clr_cnt,
  output logic                locked,
  output logic                err_pulse,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [BIT_W-1:0]    bit_cnt
);

  localparam int CNT_W = $clog2(LOCK_CNT + 32);
  localparam int WP_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam int WE_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

  state_t            state, state_next;
  logic [30:0]       c;
  logic [30:0]       c_seed;
  logic [CNT_W-1:0]  cnt;
  logic [WP_W-1:0]   win_pos;
  logic [WE_W-1:0]   win_err;
  logic              pred, miss, seed_last, win_last, loss;

  always_comb begin
    pred       = c[27] ^ c[30];
    miss       = rx.rx_bit ^ pred;
    c_seed     = {c[29:0], rx.rx_bit};
    seed_last  = (cnt == CNT_W'(30));
    win_last   = (win_pos == WP_W'(WIN_LEN - 1));
    loss       = miss && (win_err == WE_W'(LOSS_THRESH - 1));
    state_next = state;
    if (rx.rx_valid) begin
      case (state)
        SEED:    if (seed_last && (c_seed != '0)) state_next = VERIFY;
        VERIFY: begin
          if (miss)                                 state_next = SEED;
          else if (cnt == CNT_W'(LOCK_CNT - 1))     state_next = LOCKED;
        end
        LOCKED:  if (loss) state_next = SEED;
        default: state_next = SEED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) state <= SEED;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      c         <= '0;
      cnt       <= '0;
      win_pos   <= '0;
      win_err   <= '0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
      bit_cnt   <= '0;
    end else begin
      locked    <= (state_next == LOCKED);
      err_pulse <= rx.rx_valid && (state == LOCKED) && miss;
      if (rx.rx_valid) begin
        case (state)
          SEED: begin
            c   <= c_seed;
            cnt <= seed_last ? '0 : cnt + 1'b1;
          end
          VERIFY: begin
            c       <= {c[29:0], pred};
            cnt     <= miss ? '0 : cnt + 1'b1;
            win_pos <= '0;
            win_err <= '0;
          end
          LOCKED: begin
            // Flywheel: the prediction, never the received bit, feeds the register
            c       <= {c[29:0], pred};
            cnt     <= '0;
            win_pos <= win_pos + 1'b1;
            if (loss || win_last) win_err <= '0;
            else if (miss)        win_err <= win_err + 1'b1;
          end
          default: ;
        endcase
      end
      if (clr_cnt) begin
        err_cnt <= '0;
        bit_cnt <= '0;
      end else if (rx.rx_valid && (state == LOCKED)) begin
        if (bit_cnt != '1)         bit_cnt <= bit_cnt + 1'b1;
        if (miss && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prbs31_checker.sv
// tb/tb_prbs31_checker.sv - scoreboard bench for prbs31_checker against a reference model
module tb_prbs31_checker;
  localparam int LOCK_CNT    = 64;
  localparam int WIN_LEN     = 64;
  localparam int LOSS_THRESH = 8;
  localparam int HUNT = 0, CHECK = 1, TRACK = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        clr_cnt = 1'b0;
  logic        locked, err_pulse;
  logic [15:0] err_cnt;
  logic [31:0] bit_cnt;

  prbs31_checker_if rx();

  prbs31_checker dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .clr_cnt(clr_cnt),
    .locked(locked), .err_pulse(err_pulse), .err_cnt(err_cnt), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          locked;
    bit          pulse;
    int unsigned err;
    longint      bits;
  } exp_t;

  exp_t   exp_q[$];
  int     n_cmp = 0;
  int     n_fail = 0;
  bit     prbs[4096];
  bit     flips[int];
  int     sidx = 0;

  // Reference model: history of the last 31 register bits, oldest first
  bit     m_hist[$];
  int     m_mode = HUNT;
  int     m_seen, m_match, m_since, m_werr;
  int unsigned m_err;
  longint m_bits;

  task automatic model_step(input bit b, input bit v, input bit clr, input bit rst);
    exp_t e;
    bit   p;
    int   ones;
    e.pulse = 1'b0;
    if (rst) begin
      m_mode = HUNT; m_seen = 0; m_err = 0; m_bits = 0;
      m_hist.delete();
      repeat (31) m_hist.push_back(1'b0);
    end else begin
      if (v) begin
        p = m_hist[3] ^ m_hist[0];
        case (m_mode)
          HUNT: begin
            m_hist.push_back(b); void'(m_hist.pop_front());
            m_seen++;
            if (m_seen == 31) begin
              m_seen = 0;
              ones = 0;
              foreach (m_hist[i]) ones += int'(m_hist[i]);
              if (ones != 0) begin m_mode = CHECK; m_match = 0; end
            end
          end
          CHECK: begin
            m_hist.push_back(p); void'(m_hist.pop_front());
            if (b != p) begin m_mode = HUNT; m_seen = 0; end
            else begin
              m_match++;
              if (m_match == LOCK_CNT) begin m_mode = TRACK; m_since = 0; m_werr = 0; end
            end
          end
          default: begin
            m_hist.push_back(p); void'(m_hist.pop_front());
            if (m_bits < 64'hFFFF_FFFF) m_bits++;
            if (b != p) begin
              e.pulse = 1'b1;
              if (m_err < 65535) m_err++;
              m_werr++;
            end
            m_since++;
            if (m_werr == LOSS_THRESH) begin m_mode = HUNT; m_seen = 0; end
            else if (m_since % WIN_LEN == 0) m_werr = 0;
          end
        endcase
      end
      if (clr) begin m_err = 0; m_bits = 0; end
    end
    e.locked = (m_mode == TRACK);
    e.err    = m_err;
    e.bits   = m_bits;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit b, input bit v, input bit clr, input bit rst);
    @(negedge clk);
    rx.rx_bit = b; rx.rx_valid = v; clr_cnt = clr; rst_n = rst;
    model_step(b, v, clr, rst);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    sidx = 0;
    flips.delete();
  endtask

  task automatic feed(input int n, input int vpct, input int errpct, input int clrpct);
    bit b, eb, cb, rb;
    for (int i = 0; i < n; i++) begin
      while (int'($urandom_range(99)) >= vpct) begin
        rb = 1'($urandom_range(1));
        step(rb, 1'b0, 1'b0, 1'b0);
      end
      eb = (int'($urandom_range(99)) < errpct);
      cb = (int'($urandom_range(99)) < clrpct);
      b  = prbs[sidx] ^ (flips.exists(sidx) ? 1'b1 : 1'b0) ^ eb;
      step(b, 1'b1, cb, 1'b0);
      sidx++;
    end
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        if (!(locked === e.locked && err_pulse === e.pulse &&
              err_cnt === 16'(e.err) && bit_cnt === 32'(e.bits))) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: locked=%b pulse=%b err=%0d bits=%0d expected locked=%b pulse=%b err=%0d bits=%0d",
                   $time, locked, err_pulse, err_cnt, bit_cnt, e.locked, e.pulse, e.err, e.bits);
        end
      end
    end
  end

  initial begin : watchdog
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin : main
    int pcts[6] = '{0, 2, 8, 15, 0, 5};
    rx.rx_bit = 1'b0;
    rx.rx_valid = 1'b0;
    for (int n = 0; n < 4096; n++)
      prbs[n] = (n < 31) ? (n == 30) : (prbs[n-28] ^ prbs[n-31]);

    // Clean continuous stream
    do_reset(); settle();
    check("reset_locked", locked, 0);
    check("reset_err", err_cnt, 0);
    check("reset_bits", bit_cnt, 0);
    feed(94, 100, 0, 0); settle();
    check("s1_unlocked_94", locked, 0);
    feed(1, 100, 0, 0); settle();
    check("s1_locked_95", locked, 1);
    feed(905, 100, 0, 0); settle();
    check("s1_err", err_cnt, 0);
    check("s1_bits", bit_cnt, 905);

    // Single inverted bit after lock
    do_reset(); flips[200] = 1'b1;
    feed(700, 100, 0, 0); settle();
    check("s2_err", err_cnt, 1);
    check("s2_locked", locked, 1);

    // 50% valid duty
    do_reset();
    feed(1000, 50, 0, 0); settle();
    check("s3_err", err_cnt, 0);
    check("s3_bits", bit_cnt, 905);

    // All-zero input never seeds
    do_reset();
    repeat (500) step(1'b0, 1'b1, 1'b0, 1'b0);
    settle();
    check("s4_locked", locked, 0);
    check("s4_err", err_cnt, 0);

    // Eight errors in one window: loss then relock
    do_reset();
    for (int i = 150; i < 158; i++) flips[i] = 1'b1;
    feed(157, 100, 0, 0); settle();
    check("s5_locked_7err", locked, 1);
    check("s5_err7", err_cnt, 7);
    feed(1, 100, 0, 0); settle();
    check("s5_loss", locked, 0);
    check("s5_err8", err_cnt, 8);
    feed(94, 100, 0, 0); settle();
    check("s5_not_yet", locked, 0);
    feed(1, 100, 0, 0); settle();
    check("s5_relock", locked, 1);
    check("s5_err_held", err_cnt, 8);

    // Error during verify delays lock by a reseed
    do_reset(); flips[50] = 1'b1;
    feed(145, 100, 0, 0); settle();
    check("s6_delayed", locked, 0);
    feed(1, 100, 0, 0); settle();
    check("s6_locked", locked, 1);

    // Clear coincident with a locked mismatch
    do_reset();
    feed(120, 100, 0, 0);
    step(~prbs[sidx], 1'b1, 1'b1, 1'b0); sidx++;
    settle();
    check("s7_err_clr", err_cnt, 0);
    check("s7_bits_clr", bit_cnt, 0);
    feed(10, 100, 0, 0); settle();
    check("s7_bits_after", bit_cnt, 10);

    // Reset while locked
    do_reset(); flips[99] = 1'b1;
    feed(100, 100, 0, 0); settle();
    check("s8_locked", locked, 1);
    check("s8_err", err_cnt, 1);
    step(1'b0, 1'b1, 1'b0, 1'b1); settle();
    check("s8_rst_locked", locked, 0);
    check("s8_rst_pulse", err_pulse, 0);
    check("s8_rst_err", err_cnt, 0);
    check("s8_rst_bits", bit_cnt, 0);

    // Randomised error rates, valid gaps and clears
    do_reset();
    foreach (pcts[k]) feed(500, 70, pcts[k], 1);
    settle();
    repeat (2) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/prbs31_checker.md
# prbs31_checker

Receive-side counterpart of the PRBS31 pattern generator (x^31 + x^28 + 1). The block accepts the serial pattern stream one bit per valid cycle and self-synchronises by seeding a local LFSR from the received bits. Once seeded it free-runs, compares every received bit against the predicted bit, and counts bit errors. It sits at the loopback or receive end of the link under test and reports lock status and error statistics to the user-facing output mux.

## Interface
- LOCK_CNT, 64: consecutive matching bits required after seeding to declare lock.
- WIN_LEN, 64: loss-of-lock observation window, in checked bits (power of two).
- LOSS_THRESH, 8: mismatches within one window that force loss of lock.
- ERR_W, 16: error counter width.
- BIT_W, 32: checked-bit counter width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset; synchronous, active-high. The `_n` suffix follows the project port naming; the signal is not active-low.
- rx_bit  in  1  received pattern bit.
- rx_valid  in  1  rx_bit is sampled only in cycles where this is 1.
- clr_cnt  in  1  synchronous clear of err_cnt and bit_cnt.
- locked  out  1  1 while in LOCKED.
- err_pulse  out  1  one-cycle pulse per mismatch counted in LOCKED.
- err_cnt  out  ERR_W  saturating mismatch count.
- bit_cnt  out  BIT_W  saturating count of bits checked in LOCKED.

## Operation
- Local register c[30:0]. c[0] is the newest bit and c[30] the oldest. Each shift is c[30:1] <= c[29:0], with the new bit in c[0].
- Predicted bit p = c[27] ^ c[30]. This matches the generator taps, because the generator's output stream obeys o[n] = o[n-28] ^ o[n-31].
- FSM states: SEED, VERIFY, LOCKED. All events below occur only on rx_valid=1 cycles. With rx_valid=0, nothing changes.
- SEED:
  - Shift rx_bit into c and increment the seed count.
  - After the 31st bit: if the new c is all-zero, restart SEED with count 0. Otherwise go to VERIFY with the match count at 0.
- VERIFY:
  - Compare rx_bit to p, then shift p (not rx_bit) into c.
  - Match: increment the match count. On the LOCK_CNT-th match, go to LOCKED and clear the window counters.
  - Mismatch: go to SEED with the seed count at 0.
  - Errors are not counted in VERIFY.
- LOCKED:
  - Shift p into c (flywheel: errors do not corrupt the prediction).
  - Increment bit_cnt, saturating at all-ones.
  - On mismatch: pulse err_pulse, increment err_cnt (saturating), increment the window error count.
  - Window position counts 0..WIN_LEN-1. A mismatch on the last bit of a window counts toward that window, then the window error count resets to 0.
  - When the window error count reaches LOSS_THRESH: go to SEED. err_cnt and bit_cnt hold their values.
- clr_cnt=1: err_cnt and bit_cnt become 0 on that edge, overriding any coincident increment. The FSM is unaffected.
- rst_n=1, at any time including mid-lock:
  - Next edge: state SEED, c=0, all internal counters 0.
  - All outputs 0: locked, err_pulse, err_cnt, bit_cnt.

## Timing
- All outputs are registered. They update on the same edge that consumes the rx_valid bit.
- locked rises on the edge consuming the LOCK_CNT-th verify match. It falls on the edge consuming the LOSS_THRESH-th windowed mismatch.
- err_pulse is high for exactly the cycle after each mismatching LOCKED bit. err_cnt reflects that mismatch in the same cycle.
- Minimum lock time from SEED: 31 + LOCK_CNT valid bits (95 with defaults).
- Gaps in rx_valid stretch all latencies but alter no results.

## Test plan
- Generator model (seed 31'b1, serial output = MSB) drives rx_bit with rx_valid=1 continuously after reset → locked=1 after the 95th bit; after 1000 bits, err_cnt=0 and bit_cnt=905.
- Same stream, one bit inverted after lock → a single err_pulse, err_cnt=1, locked stays 1, and no further errors over the next 500 bits.
- Same stream with rx_valid randomly 50% duty → identical counts per valid bit as the first scenario.
- rx_bit held at 0 for 500 valid bits → locked never asserts, err_cnt=0.
- After lock, invert 8 consecutive bits inside one window → err_cnt=8 and locked falls on the 8th; it relocks 95 clean bits later with err_cnt still 8.
- Coincidence and reset cases:
  - Flip one bit during VERIFY → lock is delayed by a reseed.
  - clr_cnt coincident with a LOCKED mismatch → err_cnt=0.
  - rst_n pulsed while locked → all outputs 0 on the next cycle.
